// File: rtl/bus8088_pkg.sv
// bus8088_pkg
// Shared definitions for the 8088-style bus master and any responder model
// that talks to it: bus widths, the default IOM level that selects memory,
// the default wait-state limit, the bus-cycle state enum and a small helper
// that maps a command's space bit onto the IOM pin level.
package bus8088_pkg;

    localparam int   ADDR_W           = 20;
    localparam int   DATA_W           = 8;
    localparam logic ACTIVE_DEFAULT   = 1'b0;
    localparam int   MAX_WAIT_DEFAULT = 15;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_TW   = 3'd4,
        ST_T4   = 3'd5
    } bus_state_e;

    // IOM level for a command: memory drives the "active" level, I/O its inverse.
    function automatic logic iom_level(input logic io, input logic active);
        return io ? ~active : active;
    endfunction

endpackage

// File: rtl/bus_master_8088_if.sv
// bus_master_8088_if
// Groups the host command handshake and the 8088 bus control/address
// signals. The bidirectional Data bus is kept as a plain port on the master
// so tri-state resolution stays on an ordinary net.
//   master modport : used by bus_master_8088 (drives strobes, address, results)
//   slave modport  : used by the host/responder side (drives commands, READY)
interface bus_master_8088_if;
    import bus8088_pkg::*;

    // host command side
    logic              req;
    logic              we;
    logic              io;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              req_ready;
    logic              done;
    logic              err;
    logic [DATA_W-1:0] rdata;

    // bus side
    logic              ALE;
    logic              RD;
    logic              WR;
    logic              IOM;
    logic [ADDR_W-1:0] Address;
    logic              READY;

    modport master (
        input  req, we, io, addr, wdata, READY,
        output req_ready, done, err, rdata, ALE, RD, WR, IOM, Address
    );

    modport slave (
        output req, we, io, addr, wdata, READY,
        input  req_ready, done, err, rdata, ALE, RD, WR, IOM, Address
    );

endinterface

// File: rtl/bus_master_8088.sv
// bus_master_8088
// Runs one 8088-style bus cycle (T1, T2, T3, optional TW wait states, T4)
// per accepted host command. Every bus output is a flop updated by the
// single state machine, so neither req nor READY has a combinational path
// to the bus pins.
// Ports:
//   CLK   - bus clock, rising edge active
//   RESET - asynchronous, active-high
//   bus   - master modport: req/we/io/addr/wdata/req_ready/done/err/rdata
//           plus ALE/RD/WR/IOM/Address/READY
//   Data  - 8-bit bidirectional bus data, driven only during write T2..T4
// Parameters:
//   MAX_WAIT - number of TW states before the cycle aborts with err (>= 1)
//   ACTIVE   - IOM level that selects memory
module bus_master_8088
    import bus8088_pkg::*;
#(
    parameter int   MAX_WAIT = MAX_WAIT_DEFAULT,
    parameter logic ACTIVE   = ACTIVE_DEFAULT
) (
    input  logic              CLK,
    input  logic              RESET,
    bus_master_8088_if.master bus,
    inout  wire  [DATA_W-1:0] Data
);

    localparam int              CNT_W     = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
    // Value of the counter during the last permitted TW cycle.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

    bus_state_e        state_r;
    logic              we_r;
    logic [DATA_W-1:0] wdata_r;
    logic              data_oe_r;
    logic [CNT_W-1:0]  wait_cnt_r;

    // Data pins carry the latched write data only while the write is on the bus.
    assign Data = data_oe_r ? wdata_r : {DATA_W{1'bz}};

    // Bus-cycle state machine with all handshake and bus outputs registered.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_r       <= ST_IDLE;
            we_r          <= 1'b0;
            wdata_r       <= {DATA_W{1'b0}};
            data_oe_r     <= 1'b0;
            wait_cnt_r    <= {CNT_W{1'b0}};
            bus.req_ready <= 1'b1;
            bus.done      <= 1'b0;
            bus.err       <= 1'b0;
            bus.rdata     <= {DATA_W{1'b0}};
            bus.ALE       <= 1'b0;
            bus.RD        <= 1'b1;
            bus.WR        <= 1'b1;
            bus.IOM       <= ACTIVE;
            bus.Address   <= {ADDR_W{1'b0}};
        end else begin
            // done/err/ALE are single-state pulses; branches below raise them.
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            bus.ALE  <= 1'b0;

            case (state_r)
                // IDLE and T4 share acceptance so a held req chains cycles
                // with no idle gap between T4 and the next T1.
                ST_IDLE, ST_T4: begin
                    bus.RD    <= 1'b1;
                    bus.WR    <= 1'b1;
                    data_oe_r <= 1'b0;
                    if (bus.req) begin
                        state_r       <= ST_T1;
                        we_r          <= bus.we;
                        wdata_r       <= bus.wdata;
                        bus.Address   <= bus.addr;
                        bus.IOM       <= iom_level(bus.io, ACTIVE);
                        bus.ALE       <= 1'b1;
                        bus.req_ready <= 1'b0;
                    end else begin
                        state_r       <= ST_IDLE;
                        bus.req_ready <= 1'b1;
                    end
                end

                ST_T1: begin
                    state_r   <= ST_T2;
                    bus.RD    <= we_r;
                    bus.WR    <= ~we_r;
                    data_oe_r <= we_r;
                end

                ST_T2: begin
                    state_r    <= ST_T3;
                    wait_cnt_r <= {CNT_W{1'b0}};
                end

                ST_T3: begin
                    if (bus.READY) begin
                        state_r       <= ST_T4;
                        bus.done      <= 1'b1;
                        bus.req_ready <= 1'b1;
                        bus.RD        <= 1'b1;
                        bus.WR        <= 1'b1;
                        if (!we_r) begin
                            bus.rdata <= Data;
                        end else begin
                            bus.rdata <= bus.rdata;
                        end
                    end else begin
                        state_r <= ST_TW;
                    end
                end

                ST_TW: begin
                    wait_cnt_r <= wait_cnt_r + CNT_W'(1);
                    if (bus.READY) begin
                        state_r       <= ST_T4;
                        bus.done      <= 1'b1;
                        bus.req_ready <= 1'b1;
                        bus.RD        <= 1'b1;
                        bus.WR        <= 1'b1;
                        if (!we_r) begin
                            bus.rdata <= Data;
                        end else begin
                            bus.rdata <= bus.rdata;
                        end
                    end else if (wait_cnt_r == WAIT_LAST) begin
                        // Responder never answered: finish the cycle with err,
                        // leaving rdata as it was.
                        state_r       <= ST_T4;
                        bus.done      <= 1'b1;
                        bus.err       <= 1'b1;
                        bus.req_ready <= 1'b1;
                        bus.RD        <= 1'b1;
                        bus.WR        <= 1'b1;
                    end else begin
                        state_r <= ST_TW;
                    end
                end

                default: begin
                    state_r       <= ST_IDLE;
                    bus.req_ready <= 1'b1;
                    bus.RD        <= 1'b1;
                    bus.WR        <= 1'b1;
                    data_oe_r     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_master_8088.sv
// tb_bus_master_8088
// Self-checking bench for bus_master_8088. A small responder model (memory
// indexed by space bit + low address bits, programmable READY delay) sits on
// the bus; expected done timing, err and rdata are queued when each command
// is issued and popped once the cycle has been observed.
module tb_bus_master_8088;
    import bus8088_pkg::*;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;
    wire  [DATA_W-1:0] Data;

    bus_master_8088_if bus();

    bus_master_8088 #(
        .MAX_WAIT (15),
        .ACTIVE   (ACTIVE_DEFAULT)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus.master),
        .Data  (Data)
    );

    always #5 CLK = ~CLK;

    // Undriven bus reads back as all ones.
    for (genvar g = 0; g < DATA_W; g++) begin : g_pu
        pullup (Data[g]);
    end

    // ---------------- responder ----------------
    logic [7:0] mem [0:255];
    logic [7:0] mem_idx_s;
    logic [7:0] resp_data_s;
    int         strobe_cnt = 0;
    int         wait_n     = 0;
    logic       hold_low   = 1'b0;

    assign mem_idx_s   = {bus.IOM != ACTIVE_DEFAULT, bus.Address[6:0]};
    assign resp_data_s = mem[mem_idx_s];
    assign Data        = (bus.RD == 1'b0) ? resp_data_s : 8'hzz;
    assign bus.READY   = !hold_low && (strobe_cnt > wait_n + 1);

    // Count half-cycle-sampled strobe-low cycles to pace READY.
    always @(negedge CLK) begin
        if (bus.RD == 1'b0 || bus.WR == 1'b0) strobe_cnt <= strobe_cnt + 1;
        else                                  strobe_cnt <= 0;
    end

    // ---------------- scoreboard / observation ----------------
    typedef struct {
        logic [7:0] rdata;
        logic       err;
        int         cyc;
    } exp_t;
    exp_t exp_q[$];

    int n_cmp  = 0;
    int n_fail = 0;
    logic [7:0] model_rdata = 8'h00;

    int          n_done;
    int          done_cyc [2];
    logic        err_obs  [2];
    logic [7:0]  rdata_obs[2];
    logic        iom_obs  [2];
    logic [19:0] addr_obs [2];
    logic [31:0] ale_mask, rd_mask, wr_mask, dat_mask;
    int          both_low;

    // Issue a command; ok=0 if it was never accepted.
    task automatic send(input logic w, input logic io_i, input logic [19:0] a,
                        input logic [7:0] d, input logic hold, output logic ok);
        bus.req = 1'b1; bus.we = w; bus.io = io_i; bus.addr = a; bus.wdata = d;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            if (bus.req_ready) begin ok = 1'b1; break; end
            @(posedge CLK); #1;
        end
        if (ok) begin
            @(posedge CLK); #1;
            if (!hold) bus.req = 1'b0;
        end else begin
            bus.req = 1'b0;
        end
    endtask

    // Watch ncyc cycles after acceptance (cycle 1 = T1), recording strobes
    // and up to two done pulses; the responder stores write data here.
    task automatic watch(input int ncyc, input int drop_c, input logic [7:0] wval);
        n_done = 0; ale_mask = 32'h0; rd_mask = 32'h0; wr_mask = 32'h0;
        dat_mask = 32'h0; both_low = 0;
        for (int c = 1; c <= ncyc; c++) begin
            if (c == drop_c) bus.req = 1'b0;
            @(negedge CLK);
            if (bus.ALE)       ale_mask = ale_mask | (32'd1 << c);
            if (bus.RD == 1'b0) rd_mask = rd_mask | (32'd1 << c);
            if (bus.WR == 1'b0) wr_mask = wr_mask | (32'd1 << c);
            if (Data === wval)  dat_mask = dat_mask | (32'd1 << c);
            if (bus.RD == 1'b0 && bus.WR == 1'b0) both_low++;
            if (bus.WR == 1'b0) mem[mem_idx_s] = Data;
            if (bus.done && n_done < 2) begin
                done_cyc[n_done]  = c;
                err_obs[n_done]   = bus.err;
                rdata_obs[n_done] = bus.rdata;
                iom_obs[n_done]   = bus.IOM;
                addr_obs[n_done]  = bus.Address;
                n_done++;
            end
            @(posedge CLK); #1;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge CLK);
        n_cmp++; if (bus.ALE !== 1'b0) begin n_fail++; $display("FAIL rst_ale got=%b exp=0", bus.ALE); end
        n_cmp++; if (bus.RD !== 1'b1) begin n_fail++; $display("FAIL rst_rd got=%b exp=1", bus.RD); end
        n_cmp++; if (bus.WR !== 1'b1) begin n_fail++; $display("FAIL rst_wr got=%b exp=1", bus.WR); end
        n_cmp++; if (bus.IOM !== ACTIVE_DEFAULT) begin n_fail++; $display("FAIL rst_iom got=%b exp=%b", bus.IOM, ACTIVE_DEFAULT); end
        n_cmp++; if (bus.Address !== 20'h00000) begin n_fail++; $display("FAIL rst_addr got=%h exp=00000", bus.Address); end
        n_cmp++; if (bus.done !== 1'b0 || bus.err !== 1'b0) begin n_fail++; $display("FAIL rst_done_err got=%b%b exp=00", bus.done, bus.err); end
        n_cmp++; if (bus.rdata !== 8'h00) begin n_fail++; $display("FAIL rst_rdata got=%h exp=00", bus.rdata); end
        n_cmp++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready got=%b exp=1", bus.req_ready); end
        n_cmp++; if (Data !== 8'hFF) begin n_fail++; $display("FAIL rst_data_z got=%h exp=FF(pulled)", Data); end
        @(posedge CLK); #1;
        RESET = 1'b0;
    endtask

    task automatic test_mem_read();
        logic ok; exp_t e;
        model_rdata = 8'hA5;
        exp_q.push_back('{rdata: 8'hA5, err: 1'b0, cyc: 4});
        send(1'b0, 1'b0, 20'h00123, 8'h00, 1'b0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL mr_accept got=0 exp=1"); end
        watch(8, 0, 8'hA5);
        e = exp_q.pop_front();
        n_cmp++; if (n_done != 1 || done_cyc[0] != e.cyc) begin n_fail++; $display("FAIL mr_done n=%0d cyc=%0d exp=1/%0d", n_done, done_cyc[0], e.cyc); end
        n_cmp++; if (rdata_obs[0] !== e.rdata || err_obs[0] !== e.err) begin n_fail++; $display("FAIL mr_result got=%h/%b exp=%h/%b", rdata_obs[0], err_obs[0], e.rdata, e.err); end
        n_cmp++; if (ale_mask !== 32'h2) begin n_fail++; $display("FAIL mr_ale got=%h exp=2", ale_mask); end
        n_cmp++; if (rd_mask !== 32'hC || wr_mask !== 32'h0) begin n_fail++; $display("FAIL mr_strobes rd=%h wr=%h exp=C/0", rd_mask, wr_mask); end
        n_cmp++; if (iom_obs[0] !== ACTIVE_DEFAULT || addr_obs[0] !== 20'h00123) begin n_fail++; $display("FAIL mr_addr got=%b/%h exp=%b/00123", iom_obs[0], addr_obs[0], ACTIVE_DEFAULT); end
    endtask

    task automatic test_write();
        logic ok; exp_t e;
        exp_q.push_back('{rdata: model_rdata, err: 1'b0, cyc: 4});
        send(1'b1, 1'b0, 20'h7FFFF, 8'h3C, 1'b0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL wr_accept got=0 exp=1"); end
        watch(8, 0, 8'h3C);
        e = exp_q.pop_front();
        n_cmp++; if (n_done != 1 || done_cyc[0] != e.cyc) begin n_fail++; $display("FAIL wr_done n=%0d cyc=%0d exp=1/%0d", n_done, done_cyc[0], e.cyc); end
        n_cmp++; if (rdata_obs[0] !== e.rdata || err_obs[0] !== e.err) begin n_fail++; $display("FAIL wr_result got=%h/%b exp=%h/%b", rdata_obs[0], err_obs[0], e.rdata, e.err); end
        n_cmp++; if (wr_mask !== 32'hC || rd_mask !== 32'h0) begin n_fail++; $display("FAIL wr_strobes wr=%h rd=%h exp=C/0", wr_mask, rd_mask); end
        n_cmp++; if (dat_mask !== 32'h1C) begin n_fail++; $display("FAIL wr_data_window got=%h exp=1C", dat_mask); end
        // read the same location back
        model_rdata = 8'h3C;
        exp_q.push_back('{rdata: 8'h3C, err: 1'b0, cyc: 4});
        send(1'b0, 1'b0, 20'h7FFFF, 8'h00, 1'b0, ok);
        watch(8, 0, 8'h3C);
        e = exp_q.pop_front();
        n_cmp++; if (n_done != 1 || rdata_obs[0] !== e.rdata || done_cyc[0] != e.cyc) begin n_fail++; $display("FAIL wr_readback got=%h cyc=%0d exp=%h/%0d", rdata_obs[0], done_cyc[0], e.rdata, e.cyc); end
    endtask

    task automatic test_io_read();
        logic ok; exp_t e;
        wait_n = 3;
        model_rdata = 8'h5A;
        exp_q.push_back('{rdata: 8'h5A, err: 1'b0, cyc: 7});
        send(1'b0, 1'b1, 20'h00040, 8'h00, 1'b0, ok);
        watch(10, 0, 8'h5A);
        wait_n = 0;
        e = exp_q.pop_front();
        n_cmp++; if (n_done != 1 || done_cyc[0] != e.cyc) begin n_fail++; $display("FAIL io_done n=%0d cyc=%0d exp=1/%0d", n_done, done_cyc[0], e.cyc); end
        n_cmp++; if (rdata_obs[0] !== e.rdata || err_obs[0] !== e.err) begin n_fail++; $display("FAIL io_result got=%h/%b exp=%h/%b", rdata_obs[0], err_obs[0], e.rdata, e.err); end
        n_cmp++; if (iom_obs[0] !== ~ACTIVE_DEFAULT) begin n_fail++; $display("FAIL io_iom got=%b exp=%b", iom_obs[0], ~ACTIVE_DEFAULT); end
        n_cmp++; if (rd_mask !== 32'h7C) begin n_fail++; $display("FAIL io_rd_window got=%h exp=7C", rd_mask); end
    endtask

    task automatic test_timeout();
        logic ok; exp_t e;
        hold_low = 1'b1;
        // 3 setup states + 15 TW + T4 -> done in cycle 19, rdata untouched
        exp_q.push_back('{rdata: model_rdata, err: 1'b1, cyc: 19});
        send(1'b0, 1'b0, 20'h00055, 8'h00, 1'b0, ok);
        watch(22, 0, 8'hEE);
        hold_low = 1'b0;
        e = exp_q.pop_front();
        n_cmp++; if (n_done != 1 || done_cyc[0] != e.cyc) begin n_fail++; $display("FAIL to_done n=%0d cyc=%0d exp=1/%0d", n_done, done_cyc[0], e.cyc); end
        n_cmp++; if (err_obs[0] !== e.err || rdata_obs[0] !== e.rdata) begin n_fail++; $display("FAIL to_result got=%b/%h exp=%b/%h", err_obs[0], rdata_obs[0], e.err, e.rdata); end
        n_cmp++; if (rd_mask !== 32'h7FFFC) begin n_fail++; $display("FAIL to_rd_window got=%h exp=7FFFC", rd_mask); end
    endtask

    task automatic test_back_to_back();
        logic ok; exp_t e;
        exp_q.push_back('{rdata: model_rdata, err: 1'b0, cyc: 4});
        exp_q.push_back('{rdata: 8'h77, err: 1'b0, cyc: 8});
        model_rdata = 8'h77;
        send(1'b1, 1'b0, 20'h00200, 8'h77, 1'b1, ok);
        // second command waits on the held req until the first T4
        bus.we = 1'b0; bus.wdata = 8'h00;
        watch(12, 5, 8'h77);
        n_cmp++; if (n_done != 2) begin n_fail++; $display("FAIL b2b_count got=%0d exp=2", n_done); end
        for (int k = 0; k < 2; k++) begin
            e = exp_q.pop_front();
            n_cmp++; if (done_cyc[k] != e.cyc || rdata_obs[k] !== e.rdata || err_obs[k] !== e.err) begin
                n_fail++; $display("FAIL b2b_done%0d got=%0d/%h/%b exp=%0d/%h/%b", k, done_cyc[k], rdata_obs[k], err_obs[k], e.cyc, e.rdata, e.err);
            end
        end
        n_cmp++; if (ale_mask !== 32'h22) begin n_fail++; $display("FAIL b2b_ale got=%h exp=22", ale_mask); end
        n_cmp++; if (wr_mask !== 32'hC || rd_mask !== 32'hC0 || both_low != 0) begin n_fail++; $display("FAIL b2b_strobes wr=%h rd=%h both=%0d exp=C/C0/0", wr_mask, rd_mask, both_low); end
    endtask

    task automatic test_reset_mid();
        logic ok; exp_t e; int dones;
        send(1'b1, 1'b0, 20'h00300, 8'h99, 1'b0, ok);
        @(posedge CLK); #1;
        @(posedge CLK); #1;   // now in T3 of the write
        n_cmp++; if (bus.WR !== 1'b0 || Data !== 8'h99) begin n_fail++; $display("FAIL rm_pre got=%b/%h exp=0/99", bus.WR, Data); end
        RESET = 1'b1;
        #1;
        n_cmp++; if (bus.WR !== 1'b1 || bus.RD !== 1'b1 || bus.ALE !== 1'b0) begin n_fail++; $display("FAIL rm_strobes got=%b%b%b exp=110", bus.WR, bus.RD, bus.ALE); end
        n_cmp++; if (Data !== 8'hFF) begin n_fail++; $display("FAIL rm_data_z got=%h exp=FF(pulled)", Data); end
        n_cmp++; if (bus.rdata !== 8'h00 || bus.Address !== 20'h00000 || bus.IOM !== ACTIVE_DEFAULT) begin n_fail++; $display("FAIL rm_regs got=%h/%h/%b exp=00/00000/%b", bus.rdata, bus.Address, bus.IOM, ACTIVE_DEFAULT); end
        dones = 0;
        repeat (3) begin
            @(negedge CLK);
            if (bus.done) dones++;
        end
        n_cmp++; if (dones != 0) begin n_fail++; $display("FAIL rm_no_done got=%0d exp=0", dones); end
        @(posedge CLK); #1;
        RESET = 1'b0;
        model_rdata = 8'hA5;
        exp_q.push_back('{rdata: 8'hA5, err: 1'b0, cyc: 4});
        send(1'b0, 1'b0, 20'h00123, 8'h00, 1'b0, ok);
        n_cmp++; if (!ok) begin n_fail++; $display("FAIL rm_accept got=0 exp=1"); end
        watch(8, 0, 8'hA5);
        e = exp_q.pop_front();
        n_cmp++; if (n_done != 1 || done_cyc[0] != e.cyc || rdata_obs[0] !== e.rdata || err_obs[0] !== e.err) begin
            n_fail++; $display("FAIL rm_after n=%0d cyc=%0d rdata=%h err=%b exp=1/%0d/%h/%b", n_done, done_cyc[0], rdata_obs[0], err_obs[0], e.cyc, e.rdata, e.err);
        end
        n_cmp++; if (ale_mask !== 32'h2) begin n_fail++; $display("FAIL rm_ale got=%h exp=2", ale_mask); end
    endtask

    initial begin
        bus.req = 1'b0; bus.we = 1'b0; bus.io = 1'b0;
        bus.addr = 20'h00000; bus.wdata = 8'h00;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h23] = 8'hA5;
        mem[8'hC0] = 8'h5A;
        mem[8'h55] = 8'hEE;
        test_reset();
        test_mem_read();
        test_write();
        test_io_read();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

endmodule
